// File: rtl/operand_skid_buffer.sv
//------------------------------------------------------------------------------
// Module      : operand_skid_buffer
// Description : Two-entry in-order skid FIFO of {data, tag} operand pairs
//               between the source mux and the execute stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module operand_skid_buffer #(
   parameter int WIDTH = 16,
   parameter int TAGW  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic [TAGW-1:0]  in_tag,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic [WIDTH-1:0] out_data,
   output logic [TAGW-1:0]  out_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       count,
   output logic [15:0]      xfer_count
);

   localparam logic [1:0] C_EMPTY = 2'd0;
   localparam logic [1:0] C_ONE   = 2'd1;
   localparam logic [1:0] C_FULL  = 2'd2;

   logic [WIDTH-1:0] head_data_q, head_data_d;
   logic [TAGW-1:0]  head_tag_q,  head_tag_d;
   logic [WIDTH-1:0] tail_data_q, tail_data_d;
   logic [TAGW-1:0]  tail_tag_q,  tail_tag_d;
   logic [1:0]       count_q,     count_d;
   logic [15:0]      xfer_q,      xfer_d;

   logic w_push;
   logic w_pop;

   // Ready comes from registered occupancy only, so no combinational path
   // runs from out_ready back to the upstream mux.
   assign in_ready   = (count_q != C_FULL);
   assign out_valid  = (count_q != C_EMPTY);
   assign out_data   = out_valid ? head_data_q : '0;
   assign out_tag    = out_valid ? head_tag_q  : '0;
   assign count      = count_q;
   assign xfer_count = xfer_q;

   assign w_push = in_valid  & in_ready  & ~flush;
   assign w_pop  = out_valid & out_ready & ~flush;

   always_comb begin
      head_data_d = head_data_q;
      head_tag_d  = head_tag_q;
      tail_data_d = tail_data_q;
      tail_tag_d  = tail_tag_q;
      count_d     = count_q;
      xfer_d      = xfer_q + {15'd0, w_pop};

      if (flush) begin
         count_d = C_EMPTY;
      end else if (w_push && w_pop) begin
         // Only reachable at one entry: the incoming operand replaces the head.
         head_data_d = in_data;
         head_tag_d  = in_tag;
      end else if (w_push) begin
         if (count_q == C_EMPTY) begin
            head_data_d = in_data;
            head_tag_d  = in_tag;
         end else begin
            tail_data_d = in_data;
            tail_tag_d  = in_tag;
         end
         count_d = count_q + C_ONE;
      end else if (w_pop) begin
         if (count_q == C_FULL) begin
            head_data_d = tail_data_q;
            head_tag_d  = tail_tag_q;
         end
         count_d = count_q - C_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_data_q <= '0;
         head_tag_q  <= '0;
         tail_data_q <= '0;
         tail_tag_q  <= '0;
         count_q     <= C_EMPTY;
         xfer_q      <= '0;
      end else begin
         head_data_q <= head_data_d;
         head_tag_q  <= head_tag_d;
         tail_data_q <= tail_data_d;
         tail_tag_q  <= tail_tag_d;
         count_q     <= count_d;
         xfer_q      <= xfer_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_operand_skid_buffer.sv
//------------------------------------------------------------------------------
// Module      : tb_operand_skid_buffer
// Description : Directed self-checking bench for operand_skid_buffer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_operand_skid_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in_data;
   logic [1:0]  in_tag;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic [15:0] out_data;
   logic [1:0]  out_tag;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  count;
   logic [15:0] xfer_count;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   operand_skid_buffer #(.WIDTH(16), .TAGW(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_tag     (in_tag),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .flush      (flush),
      .out_data   (out_data),
      .out_tag    (out_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .count      (count),
      .xfer_count (xfer_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] t,
                        input logic r, input logic f);
      in_valid  = v;
      in_data   = d;
      in_tag    = t;
      out_ready = r;
      flush     = f;
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 16'h0, 2'd0, 1'b0, 1'b0);
      #12;
      check("rst_count",   {30'd0, count},      32'd0);
      check("rst_valid",   {31'd0, out_valid},  32'd0);
      check("rst_data",    {16'd0, out_data},   32'd0);
      check("rst_tag",     {30'd0, out_tag},    32'd0);
      check("rst_xfer",    {16'd0, xfer_count}, 32'd0);
      check("rst_inready", {31'd0, in_ready},   32'd1);
      reset = 1'b0;
      tick();

      // Single push, one-cycle latency
      drive(1'b1, 16'hA5A5, 2'd2, 1'b0, 1'b0);
      tick();
      check("p1_valid", {31'd0, out_valid}, 32'd1);
      check("p1_data",  {16'd0, out_data},  32'h0000A5A5);
      check("p1_tag",   {30'd0, out_tag},   32'd2);
      check("p1_count", {30'd0, count},     32'd1);
      drive(1'b0, 16'h0, 2'd0, 1'b1, 1'b0);
      tick();
      check("p1_pop_count", {30'd0, count},      32'd0);
      check("p1_pop_xfer",  {16'd0, xfer_count}, 32'd1);

      // Pop at empty must not count
      tick();
      check("empty_pop_xfer", {16'd0, xfer_count}, 32'd1);

      // Fill to two, ignored third push, drain in order
      drive(1'b1, 16'h0001, 2'd1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 16'h0002, 2'd3, 1'b0, 1'b0);
      tick();
      check("full_count",   {30'd0, count},    32'd2);
      check("full_inready", {31'd0, in_ready}, 32'd0);
      drive(1'b1, 16'h0003, 2'd0, 1'b0, 1'b0);
      tick();
      check("ign_count", {30'd0, count},    32'd2);
      check("ign_head",  {16'd0, out_data}, 32'h00000001);
      check("ign_tag",   {30'd0, out_tag},  32'd1);
      drive(1'b0, 16'h0, 2'd0, 1'b1, 1'b0);
      tick();
      check("drain1_head",  {16'd0, out_data},   32'h00000002);
      check("drain1_tag",   {30'd0, out_tag},    32'd3);
      check("drain1_count", {30'd0, count},      32'd1);
      check("drain1_xfer",  {16'd0, xfer_count}, 32'd2);
      tick();
      check("drain2_count", {30'd0, count},      32'd0);
      check("drain2_data",  {16'd0, out_data},   32'd0);
      check("drain2_xfer",  {16'd0, xfer_count}, 32'd3);

      // Simultaneous push and pop at one entry
      drive(1'b1, 16'h1111, 2'd1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 16'h2222, 2'd2, 1'b1, 1'b0);
      tick();
      check("pp_head",  {16'd0, out_data},   32'h00002222);
      check("pp_tag",   {30'd0, out_tag},    32'd2);
      check("pp_count", {30'd0, count},      32'd1);
      check("pp_xfer",  {16'd0, xfer_count}, 32'd4);

      // Flush overrides push and pop at full
      drive(1'b1, 16'h3333, 2'd3, 1'b0, 1'b0);
      tick();
      check("pre_flush_count", {30'd0, count}, 32'd2);
      drive(1'b1, 16'h7777, 2'd1, 1'b1, 1'b1);
      tick();
      check("flush_count", {30'd0, count},      32'd0);
      check("flush_valid", {31'd0, out_valid},  32'd0);
      check("flush_data",  {16'd0, out_data},   32'd0);
      check("flush_xfer",  {16'd0, xfer_count}, 32'd4);

      // Asynchronous reset between edges at full
      drive(1'b1, 16'h4444, 2'd0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 16'h5555, 2'd1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 16'h0, 2'd0, 1'b0, 1'b0);
      check("pre_arst_count", {30'd0, count}, 32'd2);
      #2 reset = 1'b1;
      #1;
      check("arst_count",   {30'd0, count},      32'd0);
      check("arst_valid",   {31'd0, out_valid},  32'd0);
      check("arst_inready", {31'd0, in_ready},   32'd1);
      check("arst_xfer",    {16'd0, xfer_count}, 32'd0);
      #3 reset = 1'b0;
      drive(1'b1, 16'h6666, 2'd3, 1'b0, 1'b0);
      tick();
      check("post_rst_head",  {16'd0, out_data}, 32'h00006666);
      check("post_rst_count", {30'd0, count},    32'd1);

      // 65535 push+pop cycles take xfer_count to FFFF, one more pop wraps it
      for (int i = 0; i < 65535; i++) begin
         drive(1'b1, i[15:0], 2'd0, 1'b1, 1'b0);
         tick();
      end
      check("wrap_pre_xfer", {16'd0, xfer_count}, 32'h0000FFFF);
      check("wrap_pre_head", {16'd0, out_data},   32'h0000FFFE);
      check("wrap_pre_count", {30'd0, count},     32'd1);
      drive(1'b0, 16'h0, 2'd0, 1'b1, 1'b0);
      tick();
      check("wrap_xfer",  {16'd0, xfer_count}, 32'd0);
      check("wrap_count", {30'd0, count},      32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
